leaf_hub_router: RTL and testbench

//  Parent-side hub for a multi-FPGA Helios decoder. It terminates the 64-bit parent_tx/parent_rx links of
//  NUM_FPGAS-1 leaf FPGAs.

---
 rtl/helios_router_pkg.sv | 24 ++
 rtl/hub_skid_fifo.sv | 56 +++++
 rtl/leaf_hub_router.sv | 192 +++++++++++++++++++
 tb/tb_leaf_hub_router.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/helios_router_pkg.sv
// Shared message layout and router constants for the Helios multi-FPGA decoder links.
// The field offsets and IDs defined here are used by the hub and by the leaf endpoints.
package helios_router_pkg;

  localparam int TYPE_LSB    = 60;
  localparam int TYPE_W      = 4;
  localparam int DEST_LSB    = 52;
  localparam int DEST_W      = 8;
  localparam int SRC_LSB     = 44;
  localparam int SRC_W       = 8;
  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = 44;

  localparam logic [7:0] BROADCAST_ID = 8'hFF;
  localparam logic [7:0] ROOT_ID      = 8'h00;

  typedef struct packed {
    logic [TYPE_W-1:0]    msg_type;
    logic [DEST_W-1:0]    dest;
    logic [SRC_W-1:0]     src;
    logic [PAYLOAD_W-1:0] payload;
  } msg_t;

endpackage

// File: rtl/hub_skid_fifo.sv
// Two-entry skid FIFO for one leaf upstream link; push_ready is registered from the next occupancy.
module hub_skid_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid,
  input  logic [W-1:0] push_data,
  output logic         push_ready,
  input  logic         pop,
  output logic         nempty,
  output logic [W-1:0] dout
);

  logic [W-1:0] entry0, entry1;
  logic [1:0]   occ, occ_next;
  logic         push, pop_ok;

  assign push   = push_valid && push_ready;
  assign pop_ok = pop && (occ != 2'd0);
  assign nempty = (occ != 2'd0);
  assign dout   = entry0;

  always_comb begin
    occ_next = occ;
    if (push && !pop_ok)
      occ_next = occ + 2'd1;
    else if (!push && pop_ok)
      occ_next = occ - 2'd1;
  end

  // entry0 is always the head; a full FIFO never sees a push because ready is already low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ        <= 2'd0;
      push_ready <= 1'b0;
      entry0     <= '0;
      entry1     <= '0;
    end else begin
      occ        <= occ_next;
      push_ready <= (occ_next != 2'd2);
      if (pop_ok) begin
        if (occ == 2'd2)
          entry0 <= entry1;
        else if (push)
          entry0 <= push_data;
      end else if (push) begin
        if (occ == 2'd0)
          entry0 <= push_data;
        else
          entry1 <= push_data;
      end
    end
  end

endmodule

// File: rtl/leaf_hub_router.sv
// Parent-side hub: round-robin merge of leaf traffic to the root, dest-based/broadcast fan-out to leaves,
// and link quiescence detection. Define HUB_MSG_COUNT_EN to add per-leaf up/down message counters.
module leaf_hub_router
  import helios_router_pkg::*;
#(
  parameter int  NUM_FPGAS    = 2,
  parameter int  ROUTER_DELAY = 18,
  parameter int  DATA_WIDTH   = 64,
  localparam int NUM_LEAVES   = NUM_FPGAS - 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH*NUM_LEAVES-1:0] leaf_tx_data,
  input  logic [NUM_LEAVES-1:0]            leaf_tx_valid,
  output logic [NUM_LEAVES-1:0]            leaf_tx_ready,
  output logic [DATA_WIDTH*NUM_LEAVES-1:0] leaf_rx_data,
  output logic [NUM_LEAVES-1:0]            leaf_rx_valid,
  input  logic [NUM_LEAVES-1:0]            leaf_rx_ready,
  output logic [DATA_WIDTH-1:0]            root_up_data,
  output logic                             root_up_valid,
  input  logic                             root_up_ready,
  input  logic [DATA_WIDTH-1:0]            root_dn_data,
  input  logic                             root_dn_valid,
  output logic                             root_dn_ready,
  output logic                             link_idle,
  output logic                             err_bad_dest
`ifdef HUB_MSG_COUNT_EN
  ,
  output logic [32*NUM_LEAVES-1:0]         up_msg_count,
  output logic [32*NUM_LEAVES-1:0]         dn_msg_count
`endif
);

  localparam int LW    = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1;
  localparam int CNT_W = $clog2(ROUTER_DELAY + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(ROUTER_DELAY);

  logic [DATA_WIDTH-1:0] fifo_dout [NUM_LEAVES];
  logic [NUM_LEAVES-1:0] fifo_nempty, fifo_pop;

  for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_leaf
    hub_skid_fifo #(.W(DATA_WIDTH)) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_valid (leaf_tx_valid[i]),
      .push_data  (leaf_tx_data[DATA_WIDTH*i +: DATA_WIDTH]),
      .push_ready (leaf_tx_ready[i]),
      .pop        (fifo_pop[i]),
      .nempty     (fifo_nempty[i]),
      .dout       (fifo_dout[i])
    );
  end

  function automatic logic [LW-1:0] rr_next(input logic [LW-1:0] g);
    return (int'(g) == NUM_LEAVES - 1) ? '0 : g + 1'b1;
  endfunction

  logic [LW-1:0] rr_ptr, grant;
  logic          any_req, up_load;
  msg_t          up_msg;

  // Search from rr_ptr: iterate farthest offset first so the nearest requester wins
  always_comb begin
    int idx;
    any_req = 1'b0;
    grant   = '0;
    idx     = 0;
    for (int k = NUM_LEAVES - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_LEAVES;
      if (fifo_nempty[idx]) begin
        any_req = 1'b1;
        grant   = LW'(idx);
      end
    end
  end

  assign up_load = any_req && (!root_up_valid || root_up_ready);

  always_comb begin
    for (int i = 0; i < NUM_LEAVES; i++)
      fifo_pop[i] = up_load && (grant == LW'(i));
  end

  always_comb begin
    up_msg     = msg_t'(fifo_dout[grant]);
    up_msg.src = 8'(grant) + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      root_up_valid <= 1'b0;
      root_up_data  <= '0;
      rr_ptr        <= '0;
    end else if (up_load) begin
      root_up_valid <= 1'b1;
      root_up_data  <= up_msg;
      rr_ptr        <= rr_next(grant);
    end else if (root_up_ready) begin
      root_up_valid <= 1'b0;
    end
  end

  logic                  dn_active, dn_full, dn_load, dn_bad;
  logic [DEST_W-1:0]     dn_dest;
  logic [NUM_LEAVES-1:0] dn_mask, dn_dest_mask, dn_xfer;
  logic [DATA_WIDTH-1:0] dn_data;

  assign dn_dest       = root_dn_data[DEST_LSB +: DEST_W];
  assign root_dn_ready = dn_active && !dn_full;
  assign dn_load       = root_dn_valid && root_dn_ready;
  assign dn_xfer       = dn_mask & leaf_rx_ready;
  assign leaf_rx_valid = dn_mask;
  assign leaf_rx_data  = {NUM_LEAVES{dn_data}};

  always_comb begin
    dn_dest_mask = '0;
    for (int i = 0; i < NUM_LEAVES; i++)
      if (dn_dest != ROOT_ID && (dn_dest == BROADCAST_ID || dn_dest == 8'(i + 1)))
        dn_dest_mask[i] = 1'b1;
    dn_bad = (dn_dest_mask == '0);
  end

  // An illegal dest loads an empty mask, so the register holds for one cycle and then frees
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dn_active    <= 1'b0;
      dn_full      <= 1'b0;
      dn_mask      <= '0;
      dn_data      <= '0;
      err_bad_dest <= 1'b0;
    end else begin
      dn_active <= 1'b1;
      if (dn_load) begin
        dn_full <= 1'b1;
        dn_mask <= dn_dest_mask;
        dn_data <= root_dn_data;
        if (dn_bad)
          err_bad_dest <= 1'b1;
      end else if (dn_full) begin
        dn_mask <= dn_mask & ~dn_xfer;
        dn_full <= |(dn_mask & ~dn_xfer);
      end
    end
  end

  logic             busy;
  logic [CNT_W-1:0] idle_cnt;

  assign busy = (|(leaf_tx_valid & leaf_tx_ready)) || (|dn_xfer) ||
                (root_up_valid && root_up_ready) || dn_load ||
                (|fifo_nempty) || root_up_valid || dn_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt  <= IDLE_MAX;
      link_idle <= 1'b1;
    end else begin
      if (busy)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + 1'b1;
      link_idle <= (idle_cnt == IDLE_MAX);
    end
  end

`ifdef HUB_MSG_COUNT_EN
  logic [31:0] up_cnt [NUM_LEAVES];
  logic [31:0] dn_cnt [NUM_LEAVES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LEAVES; i++) begin
        up_cnt[i] <= '0;
        dn_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LEAVES; i++) begin
        if (fifo_pop[i])
          up_cnt[i] <= up_cnt[i] + 32'd1;
        if (dn_xfer[i])
          dn_cnt[i] <= dn_cnt[i] + 32'd1;
      end
    end
  end

  for (genvar i = 0; i < NUM_LEAVES; i++) begin : g_cnt_out
    assign up_msg_count[32*i +: 32] = up_cnt[i];
    assign dn_msg_count[32*i +: 32] = dn_cnt[i];
  end
`endif

endmodule

// File: tb/tb_leaf_hub_router.sv
// Directed, table-driven bench for leaf_hub_router with three leaves and ROUTER_DELAY=18.
module tb_leaf_hub_router;

  localparam int NF = 4;
  localparam int NL = NF - 1;
  localparam int RD = 18;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [64*NL-1:0]  leaf_tx_data = '0;
  logic [NL-1:0]     leaf_tx_valid = '0;
  logic [NL-1:0]     leaf_tx_ready;
  logic [64*NL-1:0]  leaf_rx_data;
  logic [NL-1:0]     leaf_rx_valid;
  logic [NL-1:0]     leaf_rx_ready = '0;
  logic [63:0]       root_up_data;
  logic              root_up_valid;
  logic              root_up_ready = 1'b0;
  logic [63:0]       root_dn_data = '0;
  logic              root_dn_valid = 1'b0;
  logic              root_dn_ready;
  logic              link_idle;
  logic              err_bad_dest;

  leaf_hub_router #(.NUM_FPGAS(NF), .ROUTER_DELAY(RD), .DATA_WIDTH(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .leaf_tx_data  (leaf_tx_data),
    .leaf_tx_valid (leaf_tx_valid),
    .leaf_tx_ready (leaf_tx_ready),
    .leaf_rx_data  (leaf_rx_data),
    .leaf_rx_valid (leaf_rx_valid),
    .leaf_rx_ready (leaf_rx_ready),
    .root_up_data  (root_up_data),
    .root_up_valid (root_up_valid),
    .root_up_ready (root_up_ready),
    .root_dn_data  (root_dn_data),
    .root_dn_valid (root_dn_valid),
    .root_dn_ready (root_dn_ready),
    .link_idle     (link_idle),
    .err_bad_dest  (err_bad_dest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] mk(input int i, input int s);
    return {4'h7, 8'h00, 8'h00, 44'(i * 16 + s)};
  endfunction

  function automatic logic [63:0] mk_exp(input int i, input int s);
    return {4'h7, 8'h00, 8'(i + 1), 44'(i * 16 + s)};
  endfunction

  typedef struct {
    int          leaf;
    logic [63:0] din;
    logic [63:0] dout;
  } up_vec_t;

  typedef struct {
    logic [63:0]   din;
    logic [NL-1:0] mask;
  } dn_vec_t;

  up_vec_t up_tbl [4];
  dn_vec_t dn_tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0]   got [$];
    int            cyc [$];
    int            sent [NL];
    int            exp_seq [NL];
    int            rx_total;
    int            wcnt;
    int            e;
    int            ld;
    logic [63:0]   stall_data;
    logic [NL-1:0] acc;

    up_tbl[0] = '{1, 64'h1000_0000_0000_0ABC, 64'h1000_2000_0000_0ABC};
    up_tbl[1] = '{0, 64'h2FFF_FFFF_FFFF_FFFF, 64'h2FF0_1FFF_FFFF_FFFF};
    up_tbl[2] = '{1, 64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A0_25A5_A5A5_A5A5};
    up_tbl[3] = '{2, 64'h3000_0000_0000_0000, 64'h3000_3000_0000_0000};

    dn_tbl[0] = '{64'h0010_0000_0000_0111, 3'b001};
    dn_tbl[1] = '{64'h0030_0000_0000_0333, 3'b100};
    dn_tbl[2] = '{64'h0020_0000_0000_0222, 3'b010};
    dn_tbl[3] = '{64'h0FF0_0000_0000_0FFF, 3'b111};

    // reset state
    tick();
    tick();
    chk("rst_tx_ready", leaf_tx_ready, 0);
    chk("rst_dn_ready", root_dn_ready, 0);
    chk("rst_up_valid", root_up_valid, 0);
    chk("rst_up_data", root_up_data, 0);
    chk("rst_rx_valid", leaf_rx_valid, 0);
    chk("rst_link_idle", link_idle, 1);
    chk("rst_err", err_bad_dest, 0);
    reset = 1'b1;
    tick();
    tick();
    chk("rel_tx_ready", leaf_tx_ready, 3'b111);
    chk("rel_dn_ready", root_dn_ready, 1);

    // upstream single-beat table
    root_up_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      leaf_tx_data[64*up_tbl[v].leaf +: 64] = up_tbl[v].din;
      leaf_tx_valid = '0;
      leaf_tx_valid[up_tbl[v].leaf] = 1'b1;
      chk("up_tx_ready", leaf_tx_ready[up_tbl[v].leaf], 1);
      tick();
      leaf_tx_valid = '0;
      chk("up_not_yet", root_up_valid, 0);
      tick();
      chk("up_valid", root_up_valid, 1);
      chk("up_data", root_up_data, up_tbl[v].dout);
      tick();
      chk("up_single_beat", root_up_valid, 0);
    end

    // downstream routing table, all leaves ready
    leaf_rx_ready = '1;
    for (int v = 0; v < 4; v++) begin
      root_dn_data  = dn_tbl[v].din;
      root_dn_valid = 1'b1;
      chk("dn_ready", root_dn_ready, 1);
      tick();
      root_dn_valid = 1'b0;
      chk("dn_mask", leaf_rx_valid, dn_tbl[v].mask);
      for (int i = 0; i < NL; i++)
        if (dn_tbl[v].mask[i])
          chk("dn_data", leaf_rx_data[64*i +: 64], dn_tbl[v].din);
      tick();
      chk("dn_done", leaf_rx_valid, 0);
      chk("dn_ready_back", root_dn_ready, 1);
    end

    // round-robin order with two messages per leaf
    for (int i = 0; i < NL; i++) leaf_tx_data[64*i +: 64] = mk(i, 0);
    leaf_tx_valid = '1;
    tick();
    for (int i = 0; i < NL; i++) leaf_tx_data[64*i +: 64] = mk(i, 1);
    tick();
    leaf_tx_valid = '0;
    for (int c = 0; c < 20; c++) begin
      if (root_up_valid) begin
        got.push_back(root_up_data);
        cyc.push_back(c);
      end
      tick();
    end
    chk("rr_count", got.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < got.size())
        chk("rr_order", got[k], mk_exp(k % 3, k / 3));
    if (cyc.size() == 6)
      chk("rr_back_to_back", cyc[5] - cyc[0], 5);

    // root stall under full load, four messages per leaf
    rx_total = 0;
    stall_data = '0;
    for (int i = 0; i < NL; i++) begin
      sent[i] = 0;
      exp_seq[i] = 0;
      leaf_tx_data[64*i +: 64] = mk(i, 0);
    end
    leaf_tx_valid = '1;
    for (int c = 0; c < 100; c++) begin
      root_up_ready = (c >= 8);
      acc = leaf_tx_valid & leaf_tx_ready;
      if (c == 2) stall_data = root_up_data;
      if (c == 7) begin
        chk("stall_valid", root_up_valid, 1);
        chk("stall_data", root_up_data, stall_data);
        chk("stall_tx_ready", leaf_tx_ready, 0);
      end
      if (root_up_valid && root_up_ready) begin
        ld = int'(root_up_data[7:4]);
        chk("stall_src", root_up_data[51:44], 64'(ld + 1));
        if (ld < NL) begin
          chk("stall_seq", root_up_data[3:0], 64'(exp_seq[ld]));
          exp_seq[ld]++;
        end
        rx_total++;
      end
      tick();
      for (int i = 0; i < NL; i++)
        if (acc[i]) begin
          sent[i]++;
          if (sent[i] < 4) leaf_tx_data[64*i +: 64] = mk(i, sent[i]);
          else leaf_tx_valid[i] = 1'b0;
        end
    end
    chk("stall_total", rx_total, 12);

    // broadcast with leaf 1 held off
    leaf_rx_ready = 3'b101;
    root_dn_data  = 64'h9FF0_0000_0000_00BB;
    root_dn_valid = 1'b1;
    chk("bc_accept", root_dn_ready, 1);
    tick();
    root_dn_valid = 1'b0;
    chk("bc_all_valid", leaf_rx_valid, 3'b111);
    tick();
    chk("bc_first", leaf_rx_valid, 3'b010);
    chk("bc_busy", root_dn_ready, 0);
    tick();
    tick();
    tick();
    chk("bc_hold", leaf_rx_valid, 3'b010);
    chk("bc_data_l1", leaf_rx_data[64 +: 64], 64'h9FF0_0000_0000_00BB);
    leaf_rx_ready = 3'b111;
    tick();
    chk("bc_done", leaf_rx_valid, 0);
    chk("bc_ready_back", root_dn_ready, 1);

    // illegal destination, then a normal message
    root_dn_data  = 64'h0400_0000_0000_0044;
    root_dn_valid = 1'b1;
    tick();
    root_dn_valid = 1'b0;
    chk("bad_no_valid", leaf_rx_valid, 0);
    chk("bad_err", err_bad_dest, 1);
    chk("bad_busy", root_dn_ready, 0);
    tick();
    chk("bad_freed", root_dn_ready, 1);
    chk("bad_err_sticky", err_bad_dest, 1);
    root_dn_data  = 64'h0020_0000_0000_0055;
    root_dn_valid = 1'b1;
    tick();
    root_dn_valid = 1'b0;
    chk("after_bad_mask", leaf_rx_valid, 3'b010);
    chk("after_bad_data", leaf_rx_data[64 +: 64], 64'h0020_0000_0000_0055);
    tick();
    chk("after_bad_done", leaf_rx_valid, 0);
    chk("after_bad_err", err_bad_dest, 1);

    // link_idle timing after the last transfer
    root_up_ready = 1'b1;
    leaf_tx_data[64 +: 64] = 64'h1;
    leaf_tx_valid = 3'b010;
    tick();
    leaf_tx_valid = '0;
    wcnt = 0;
    while (!root_up_valid && wcnt < 10) begin
      tick();
      wcnt++;
    end
    chk("idle_pre_valid", root_up_valid, 1);
    tick();
    chk("idle_low_after_xfer", link_idle, 0);
    e = 0;
    while (!link_idle && e < 40) begin
      tick();
      e++;
    end
    chk("idle_edges", e, RD + 1);

    // reset in the middle of a broadcast
    leaf_rx_ready = '0;
    root_dn_data  = 64'h0FF0_0000_0000_0CCC;
    root_dn_valid = 1'b1;
    tick();
    root_dn_valid = 1'b0;
    chk("mid_bc_valid", leaf_rx_valid, 3'b111);
    reset = 1'b0;
    #1;
    chk("mid_rst_rx_valid", leaf_rx_valid, 0);
    chk("mid_rst_up_valid", root_up_valid, 0);
    chk("mid_rst_dn_ready", root_dn_ready, 0);
    chk("mid_rst_tx_ready", leaf_tx_ready, 0);
    chk("mid_rst_idle", link_idle, 1);
    chk("mid_rst_err", err_bad_dest, 0);
    tick();
    reset = 1'b1;
    leaf_rx_ready = '1;
    tick();
    tick();
    chk("post_rst_no_delivery", leaf_rx_valid, 0);
    chk("post_rst_dn_ready", root_dn_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
